// File: rtl/regfile_access_sequencer_if.sv
// Fetch, register-file access and OUT-consumer signals of the register file access sequencer.
interface regfile_access_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = 2
);
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_data;
    logic                  instr_ready;
    logic                  register_enable;
    logic                  read_write;
    logic [SEL_WIDTH-1:0]  register_select_destination;
    logic [SEL_WIDTH-1:0]  register_select_source;
    logic                  direct_immediate;
    logic [DATA_WIDTH-1:0] data_bus_out;
    logic [DATA_WIDTH-1:0] data_bus_in;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // master is the sequencer side
    modport master (
        input  instr_valid, instr_data, data_bus_in, out_ready,
        output instr_ready, register_enable, read_write, register_select_destination,
               register_select_source, direct_immediate, data_bus_out, out_valid, out_data
    );

    modport slave (
        output instr_valid, instr_data, data_bus_in, out_ready,
        input  instr_ready, register_enable, read_write, register_select_destination,
               register_select_source, direct_immediate, data_bus_out, out_valid, out_data
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Instruction sequencer driving the register file access port (read, capture, add, write back).
// Define SEQ_SUB_EN to enable opcode 0x6 SUB rd,rs; otherwise 0x6 is illegal.
module regfile_access_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SEL_WIDTH    = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_access_sequencer_if.master bus,
    output logic                       flag_z,
    output logic                       flag_c,
    output logic                       done,
    output logic                       illegal
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = DATA_WIDTH + 1;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h4;
    localparam logic [OP_W-1:0] OP_OUT  = 4'h5;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h6;

`ifdef SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, IMM, RD_A, CAP_A, RD_B, CAP_B, WRITE, OUT
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [OP_W-1:0]       op_q;
    logic [SEL_WIDTH-1:0]  rd_q, rs_q;
    logic [DATA_WIDTH-1:0] imm_q, a_q, b_q;
    logic                  done_q;

    logic                  accept_c, cap_last_c, is_sub_c, legal_c, out_fire_c;
    logic [OP_W-1:0]       op_c;
    logic [SEL_WIDTH-1:0]  rd_c, rs_c;
    logic [DATA_WIDTH-1:0] a_c, b_c, imm_c;
    logic [SUM_W-1:0]      result_c;

    logic                  instr_ready_nxt, register_enable_nxt, read_write_nxt;
    logic [SEL_WIDTH-1:0]  sel_dst_nxt, sel_src_nxt;
    logic [DATA_WIDTH-1:0] data_bus_out_nxt, out_data_nxt;
    logic                  out_valid_nxt, flag_z_nxt, flag_c_nxt, done_nxt, illegal_nxt;

    // In IDLE the fields come straight off the bus so the first strobe can be registered on accept
    assign accept_c   = bus.instr_valid && bus.instr_ready;
    assign cap_last_c = (cnt == CNT_W'(READ_LATENCY - 1));
    assign op_c       = (state == IDLE) ? bus.instr_data[DATA_WIDTH-1 -: OP_W] : op_q;
    assign rd_c       = (state == IDLE) ? bus.instr_data[2*SEL_WIDTH-1 : SEL_WIDTH] : rd_q;
    assign rs_c       = (state == IDLE) ? bus.instr_data[SEL_WIDTH-1:0] : rs_q;
    assign is_sub_c   = SUB_EN && (op_c == OP_SUB);
    assign legal_c    = (op_c <= OP_OUT) || is_sub_c;
    assign out_fire_c = (state == OUT) && bus.out_ready;

    // Operands bypass their capture registers on the edge that loads them
    assign a_c   = (state == CAP_A) ? bus.data_bus_in : a_q;
    assign b_c   = (state == CAP_B) ? bus.data_bus_in : b_q;
    assign imm_c = (state == IMM)   ? bus.instr_data  : imm_q;

    // OUT completes combinationally on the consumer handshake
    assign done = done_q | out_fire_c;
    assign bus.direct_immediate = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (op_c == OP_LDI || op_c == OP_ADDI) begin
                        state_nxt = IMM;
                    end else if (op_c == OP_MOV || op_c == OP_ADD || op_c == OP_OUT || is_sub_c) begin
                        state_nxt = RD_A;
                    end
                end
            end
            IMM:   if (bus.instr_valid) state_nxt = (op_c == OP_LDI) ? WRITE : RD_B;
            RD_A:  state_nxt = CAP_A;
            CAP_A: begin
                if (cap_last_c) begin
                    if (op_c == OP_MOV)      state_nxt = WRITE;
                    else if (op_c == OP_OUT) state_nxt = OUT;
                    else                     state_nxt = RD_B;
                end
            end
            RD_B:  state_nxt = CAP_B;
            CAP_B: if (cap_last_c) state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
            OUT:   if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result is one bit wider than the data path; the top bit is carry (or borrow for SUB)
    always_comb begin
        result_c = '0;
        case (op_c)
            OP_MOV:  result_c = SUM_W'(a_c);
            OP_LDI:  result_c = SUM_W'(imm_c);
            OP_ADD:  result_c = SUM_W'(a_c) + SUM_W'(b_c);
            OP_ADDI: result_c = SUM_W'(b_c) + SUM_W'(imm_c);
            default: if (is_sub_c) result_c = SUM_W'(b_c) - SUM_W'(a_c);
        endcase
    end

    always_comb begin
        instr_ready_nxt     = (state_nxt == IDLE) || (state_nxt == IMM);
        register_enable_nxt = (state_nxt == RD_A) || (state_nxt == RD_B) || (state_nxt == WRITE);
        read_write_nxt      = (state_nxt == RD_A) || (state_nxt == RD_B);
        sel_dst_nxt         = bus.register_select_destination;
        sel_src_nxt         = bus.register_select_source;
        data_bus_out_nxt    = bus.data_bus_out;
        out_valid_nxt       = (state_nxt == OUT);
        out_data_nxt        = bus.out_data;
        flag_z_nxt          = flag_z;
        flag_c_nxt          = flag_c;
        done_nxt            = (state_nxt == WRITE) || ((state == IDLE) && accept_c && (op_c == OP_NOP));
        illegal_nxt         = (state == IDLE) && accept_c && !legal_c;

        case (state_nxt)
            RD_A:  sel_src_nxt = (op_c == OP_OUT) ? rd_c : rs_c;
            RD_B:  sel_src_nxt = rd_c;
            WRITE: begin
                sel_dst_nxt      = rd_c;
                data_bus_out_nxt = result_c[DATA_WIDTH-1:0];
                if (op_c == OP_ADD || op_c == OP_ADDI || is_sub_c) begin
                    flag_c_nxt = result_c[DATA_WIDTH];
                    flag_z_nxt = (result_c[DATA_WIDTH-1:0] == '0);
                end
            end
            OUT:   if (state == CAP_A) out_data_nxt = a_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt                             <= '0;
            op_q                            <= '0;
            rd_q                            <= '0;
            rs_q                            <= '0;
            imm_q                           <= '0;
            a_q                             <= '0;
            b_q                             <= '0;
            done_q                          <= 1'b0;
            illegal                         <= 1'b0;
            flag_z                          <= 1'b0;
            flag_c                          <= 1'b0;
            bus.instr_ready                 <= 1'b1;
            bus.register_enable             <= 1'b0;
            bus.read_write                  <= 1'b0;
            bus.register_select_destination <= '0;
            bus.register_select_source      <= '0;
            bus.data_bus_out                <= '0;
            bus.out_valid                   <= 1'b0;
            bus.out_data                    <= '0;
        end else begin
            if ((state == IDLE) && accept_c) begin
                op_q <= op_c;
                rd_q <= rd_c;
                rs_q <= rs_c;
            end
            if ((state == IMM) && bus.instr_valid) imm_q <= bus.instr_data;
            if ((state == CAP_A) && cap_last_c)    a_q   <= bus.data_bus_in;
            if ((state == CAP_B) && cap_last_c)    b_q   <= bus.data_bus_in;
            if (((state == CAP_A) || (state == CAP_B)) && !cap_last_c) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            done_q                          <= done_nxt;
            illegal                         <= illegal_nxt;
            flag_z                          <= flag_z_nxt;
            flag_c                          <= flag_c_nxt;
            bus.instr_ready                 <= instr_ready_nxt;
            bus.register_enable             <= register_enable_nxt;
            bus.read_write                  <= read_write_nxt;
            bus.register_select_destination <= sel_dst_nxt;
            bus.register_select_source      <= sel_src_nxt;
            bus.data_bus_out                <= data_bus_out_nxt;
            bus.out_valid                   <= out_valid_nxt;
            bus.out_data                    <= out_data_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Randomized self-checking bench for regfile_access_sequencer against an instruction-level model.
module tb_regfile_access_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 2;

`ifdef SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        int          t;
        logic [1:0]  dst;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flag_z, flag_c, done, illegal;

    regfile_access_sequencer_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) ifc ();

    regfile_access_sequencer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .READ_LATENCY(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifc),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] env_rf [4];
    logic [7:0] m_rf [4];
    logic       m_fz, m_fc;
    logic [1:0] rd_log [$];
    wr_t        wr_log [$];
    int         done_log [$];
    int         ill_log [$];
    logic       rd_pend = 1'b0;
    logic [1:0] rd_sel = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Register file: logs strobes, commits writes, returns read data one cycle after the strobe
    always @(negedge clk) begin
        rd_pend = rst_n && ifc.register_enable && ifc.read_write;
        if (rd_pend) begin
            rd_sel = ifc.register_select_source;
            rd_log.push_back(ifc.register_select_source);
        end
        if (rst_n && ifc.register_enable && !ifc.read_write) begin
            wr_log.push_back('{cyc, ifc.register_select_destination, ifc.data_bus_out});
            env_rf[ifc.register_select_destination] = ifc.data_bus_out;
        end
        if (done)    done_log.push_back(cyc);
        if (illegal) ill_log.push_back(cyc);
    end

    always @(posedge clk) begin
        #1;
        if (rd_pend) ifc.data_bus_in = env_rf[rd_sel];
        else         ifc.data_bus_in = 8'($urandom);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   ifc.instr_ready, 1);
        check({tag, "_en"},      ifc.register_enable, 0);
        check({tag, "_rw"},      ifc.read_write, 0);
        check({tag, "_dst"},     ifc.register_select_destination, 0);
        check({tag, "_src"},     ifc.register_select_source, 0);
        check({tag, "_dimm"},    ifc.direct_immediate, 0);
        check({tag, "_dout"},    ifc.data_bus_out, 0);
        check({tag, "_ovalid"},  ifc.out_valid, 0);
        check({tag, "_odata"},   ifc.out_data, 0);
        check({tag, "_flags"},   {flag_z, flag_c}, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_illegal"}, illegal, 0);
    endtask

    // Called at posedge+1; returns with valid dropped at posedge+1 after the transfer
    task automatic send_byte(input logic [7:0] b, output int t);
        int n;
        n = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr_data  = b;
        @(negedge clk);
        while (ifc.instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", ifc.instr_ready, 1);
        t = cyc;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        ifc.instr_data  = 8'($urandom);
    endtask

    task automatic run_instr(input logic [7:0] ib, input logic [7:0] imm, input int stall, input int hold);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] a, b, exp_data;
        logic       exp_c;
        logic [1:0] exp_rd [$];
        bit         legal, has_wr, has_out, upd;
        int         t0, ti, tw, t_hs, t_done, n, s;

        op = ib[7:4]; rd = ib[3:2]; rs = ib[1:0];
        a = m_rf[rs]; b = m_rf[rd];
        legal   = (op <= 4'h5) || (SUB_EN && op == 4'h6);
        has_wr  = legal && (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6});
        has_out = (op == 4'h5);
        upd     = legal && (op inside {4'h3, 4'h4, 4'h6});
        exp_data = '0; exp_c = 1'b0; ti = 0; t_hs = 0; s = 0;
        case (op)
            4'h1: begin exp_rd.push_back(rs); exp_data = a; end
            4'h2: exp_data = imm;
            4'h3: begin
                exp_rd.push_back(rs); exp_rd.push_back(rd);
                s = int'(a) + int'(b); exp_data = 8'(s); exp_c = (s > 255);
            end
            4'h4: begin
                exp_rd.push_back(rd);
                s = int'(b) + int'(imm); exp_data = 8'(s); exp_c = (s > 255);
            end
            4'h5: begin exp_rd.push_back(rd); exp_data = b; end
            4'h6: if (SUB_EN) begin
                exp_rd.push_back(rs); exp_rd.push_back(rd);
                s = int'(b) - int'(a); exp_data = 8'(s); exp_c = (b < a);
            end
            default: ;
        endcase

        @(posedge clk);
        #1;
        rd_log.delete(); wr_log.delete(); done_log.delete(); ill_log.delete();
        send_byte(ib, t0);
        if (legal && (op == 4'h2 || op == 4'h4)) begin
            repeat (stall) @(posedge clk);
            if (stall > 0) #1;
            send_byte(imm, ti);
        end
        case (op)
            4'h1:    tw = t0 + 3;
            4'h2:    tw = ti + 1;
            4'h4:    tw = ti + 3;
            default: tw = t0 + 5;
        endcase

        if (has_out) begin
            n = 0;
            while (ifc.out_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("out_wait", n < 20, 1);
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                check("out_valid_hold", ifc.out_valid, 1);
                check("out_data_hold", ifc.out_data, exp_data);
                check("out_done_early", done, 0);
            end
            @(posedge clk);
            #1;
            ifc.out_ready = 1'b1;
            @(negedge clk);
            t_hs = cyc;
            check("out_hs_valid", ifc.out_valid, 1);
            check("out_hs_data", ifc.out_data, exp_data);
            check("out_hs_done", done, 1);
            @(posedge clk);
            #1;
            ifc.out_ready = 1'b0;
        end else begin
            n = 0;
            while (!(done === 1'b1 || illegal === 1'b1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("done_wait", n < 20, 1);
        end
        repeat (3) @(negedge clk);

        check("rd_count", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) check("rd_sel", rd_log[i], exp_rd[i]);
        check("wr_count", wr_log.size(), has_wr);
        if (has_wr && wr_log.size() > 0) begin
            check("wr_dst", wr_log[0].dst, rd);
            check("wr_data", wr_log[0].data, exp_data);
            check("wr_cycle", wr_log[0].t - t0, tw - t0);
        end
        t_done = has_wr ? tw : (has_out ? t_hs : t0 + 1);
        check("done_count", done_log.size(), legal);
        if (legal && done_log.size() > 0) check("done_cycle", done_log[0] - t0, t_done - t0);
        check("illegal_count", ill_log.size(), !legal);
        if (!legal && ill_log.size() > 0) check("illegal_cycle", ill_log[0] - t0, 1);

        if (has_wr) m_rf[rd] = exp_data;
        if (upd) begin
            m_fc = exp_c;
            m_fz = (exp_data == 8'h00);
        end
        check("flag_z", flag_z, m_fz);
        check("flag_c", flag_c, m_fc);
        check("end_ready", ifc.instr_ready, 1);
        check("end_ovalid", ifc.out_valid, 0);
    endtask

    task automatic reset_mid_add();
        int t0;
        @(posedge clk);
        #1;
        rd_log.delete(); wr_log.delete(); done_log.delete();
        send_byte(8'h3D, t0);
        while (cyc < t0 + 4) @(negedge clk);
        check("capb_en", ifc.register_enable, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check("midrst_reads", rd_log.size(), 2);
        check("midrst_writes", wr_log.size(), 0);
        check("midrst_done", done_log.size(), 0);
        m_fz = 1'b0;
        m_fc = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.instr_data  = '0;
        ifc.out_ready   = 1'b0;
        m_fz = 1'b0;
        m_fc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            env_rf[i] = 8'($urandom);
            m_rf[i]   = env_rf[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        run_instr(8'h28, 8'h5A, 0, 1);
        run_instr(8'h24, 8'hF0, 0, 1);
        run_instr(8'h2C, 8'h20, 2, 1);
        run_instr(8'h3D, 8'h00, 0, 1);
        run_instr(8'h20, 8'h01, 0, 1);
        run_instr(8'h40, 8'hFF, 3, 1);
        run_instr(8'h28, 8'hA5, 0, 1);
        run_instr(8'h58, 8'h00, 0, 4);
        run_instr(8'hE0, 8'h00, 0, 1);
        run_instr(8'h00, 8'h00, 0, 1);
        run_instr(8'h24, 8'h03, 0, 1);
        run_instr(8'h2C, 8'h05, 0, 1);
        run_instr(8'h67, 8'h00, 0, 1);
        run_instr(8'h35, 8'h00, 0, 1);
        run_instr(8'h24, 8'hF0, 0, 1);
        run_instr(8'h2C, 8'h20, 0, 1);
        reset_mid_add();
        run_instr(8'h3D, 8'h00, 0, 1);

        for (int k = 0; k < 200; k++) begin
            logic [7:0] ib;
            ib = 8'($urandom);
            if ($urandom_range(0, 9) < 8) ib[7:4] = 4'($urandom_range(0, 6));
            run_instr(ib, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
